// File: rtl/spatz_mem_responder.sv
// Spatz VLSU memory responder: word-addressed SRAM with in-order, credit-protected responses.
// Optional SPATZ_MEM_RSP_STORE_ACK_EN: every accepted store also returns an ack response.

package spatz_pkg;
    localparam int ELEN   = 32;
    localparam int ELENB  = ELEN / 8;
    localparam int NRVREG = 32;
    localparam int IdW    = $clog2(NRVREG);

    typedef struct packed {
        logic [IdW:0]     id;
        logic [31:0]      addr;
        logic [1:0]       mode;
        logic [1:0]       size;
        logic             we;
        logic [ELENB-1:0] strb;
        logic [ELEN-1:0]  wdata;
        logic             last;
        logic             spec;
    } spatz_mem_req_t;

    typedef struct packed {
        logic [IdW-1:0]  id;
        logic [ELEN-1:0] rdata;
        logic            err;
    } spatz_mem_resp_t;
endpackage

module spatz_mem_responder
    import spatz_pkg::*;
#(
    parameter int unsigned NumWords     = 1024,
    parameter logic [31:0] BaseAddr     = 32'h0000_0000,
    parameter int unsigned RspFifoDepth = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [$bits(spatz_mem_req_t)-1:0]  mem_req_i,
    input  logic                               mem_req_valid_i,
    output logic                               mem_req_ready_o,
    output logic [$bits(spatz_mem_resp_t)-1:0] mem_rsp_o,
    output logic                               mem_rsp_valid_o,
    input  logic                               mem_rsp_ready_i
);

    localparam int unsigned IdxW = $clog2(NumWords);
    localparam int unsigned OffW = $clog2(ELENB);
    localparam int unsigned PtrW = $clog2(RspFifoDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [31:0] SpanBytes = 32'(NumWords * ELENB);

    spatz_mem_req_t  req;
    logic [ELEN-1:0] mem_q [NumWords];
    spatz_mem_resp_t fifo_q [RspFifoDepth];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            infl_q, infl_d;
    spatz_mem_resp_t infl_rsp_q, infl_rsp_d;

    logic [31:0]     off;
    logic [IdxW-1:0] idx;
    logic            in_range, req_ready, req_fire, produces;
    logic            st_en;
    logic [ELEN-1:0] st_word, rd_word;
    logic [CntW:0]   used;
    spatz_mem_resp_t head;
    logic            head_valid, pop, byp, fifo_pop, push;
    logic            unused_ok;

    assign req = spatz_mem_req_t'(mem_req_i);

    always_comb begin
        off      = req.addr - BaseAddr;
        in_range = (req.addr >= BaseAddr) && (off < SpanBytes);
        idx      = off[OffW +: IdxW];
        used     = {1'b0, cnt_q} + (CntW + 1)'(infl_q);
        // Credits cover both queued entries and the load still in the read stage
        req_ready = !rst_i && (used < (CntW + 1)'(RspFifoDepth));
        req_fire  = mem_req_valid_i && req_ready;
`ifdef SPATZ_MEM_RSP_STORE_ACK_EN
        produces = 1'b1;
`else
        produces = !req.we;
`endif
        rd_word = in_range ? mem_q[idx] : '0;
        st_en   = req_fire && req.we && in_range;
        st_word = mem_q[idx];
        for (int b = 0; b < ELENB; b++) begin
            if (req.strb[b]) st_word[8*b +: 8] = req.wdata[8*b +: 8];
        end
    end

    always_comb begin
        head       = (cnt_q == '0) ? infl_rsp_q : fifo_q[rd_ptr_q];
        head_valid = (cnt_q != '0) || infl_q;
        pop        = head_valid && mem_rsp_ready_i && !rst_i;
        // With an empty FIFO the staged response is presented directly
        byp        = pop && (cnt_q == '0);
        fifo_pop   = pop && (cnt_q != '0);
        push       = infl_q && !byp && !rst_i;

        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(fifo_pop);
        cnt_d    = cnt_q + CntW'(push) - CntW'(fifo_pop);

        infl_d           = req_fire && produces;
        infl_rsp_d.id    = req.id[IdW-1:0];
        infl_rsp_d.rdata = req.we ? '0 : rd_word;
        infl_rsp_d.err   = !in_range && !req.spec;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            infl_q     <= 1'b0;
            infl_rsp_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            infl_q     <= infl_d;
            infl_rsp_q <= infl_rsp_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (st_en) mem_q[idx] <= st_word;
        if (push) fifo_q[wr_ptr_q] <= infl_rsp_q;
    end

    assign mem_req_ready_o = req_ready;
    assign mem_rsp_valid_o = head_valid && !rst_i;
    assign mem_rsp_o       = rst_i ? '0 : head;

    assign unused_ok = ^{req.mode, req.size, req.last, off};

    assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !fifo_pop && cnt_q == CntW'(RspFifoDepth)));

    assert property (@(posedge clk_i) disable iff (rst_i)
        (mem_req_valid_i && !mem_req_ready_o) |=> $stable(mem_req_i));

endmodule

// File: tb/tb_spatz_mem_responder.sv
// Randomized scoreboard bench for spatz_mem_responder.
// Honours SPATZ_MEM_RSP_STORE_ACK_EN when defined for the build.

module tb_spatz_mem_responder;
    import spatz_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          NW    = 1024;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic [$bits(spatz_mem_req_t)-1:0]  mem_req_i = '0;
    logic                               mem_req_valid_i = 1'b0;
    logic                               mem_req_ready_o;
    logic [$bits(spatz_mem_resp_t)-1:0] mem_rsp_o;
    logic                               mem_rsp_valid_o;
    logic                               mem_rsp_ready_i = 1'b0;

    spatz_mem_responder #(
        .NumWords(NW), .BaseAddr(BASE), .RspFifoDepth(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_req_i(mem_req_i), .mem_req_valid_i(mem_req_valid_i),
        .mem_req_ready_o(mem_req_ready_o),
        .mem_rsp_o(mem_rsp_o), .mem_rsp_valid_o(mem_rsp_valid_o),
        .mem_rsp_ready_i(mem_rsp_ready_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;
    spatz_mem_resp_t exp_q[$];
    logic [31:0] model_mem [int];
    spatz_mem_resp_t last_rsp = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic spatz_mem_resp_t mk(input logic [4:0] id, input logic [31:0] d, input logic e);
        spatz_mem_resp_t r;
        r.id = id; r.rdata = d; r.err = e;
        return r;
    endfunction

    // Reference: flat word array, responses in acceptance order
    task automatic model_accept(input spatz_mem_req_t r);
        bit in;
        int idx;
        logic [31:0] w;
        in  = (r.addr >= BASE) && ((r.addr - BASE) < NW * 4);
        idx = int'((r.addr - BASE) / 4);
        if (!r.we) begin
            exp_q.push_back(mk(r.id[4:0], in ? model_mem[idx] : 32'h0, !in && !r.spec));
        end else begin
            if (in) begin
                w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (r.strb[b]) w[8*b +: 8] = r.wdata[8*b +: 8];
                model_mem[idx] = w;
            end
`ifdef SPATZ_MEM_RSP_STORE_ACK_EN
            exp_q.push_back(mk(r.id[4:0], 32'h0, !in && !r.spec));
`endif
        end
        acc_cnt++;
    endtask

    task automatic send(input spatz_mem_req_t r);
        bit ok;
        ok = 1'b0;
        mem_req_i = r;
        mem_req_valid_i = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (mem_req_ready_o) begin
                model_accept(r);
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        mem_req_valid_i = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got ready=0 want ready=1 addr=%h", r.addr);
        end
    endtask

    function automatic spatz_mem_req_t mkreq(input logic [5:0] id, input logic [31:0] addr,
                                             input logic we, input logic [3:0] strb,
                                             input logic [31:0] wdata, input logic spec);
        spatz_mem_req_t r;
        r = '0;
        r.id = id; r.addr = addr; r.we = we; r.strb = strb;
        r.wdata = wdata; r.spec = spec;
        return r;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        mem_rsp_ready_i = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops on each handshake, checks hold while stalled
    spatz_mem_resp_t held;
    spatz_mem_resp_t got;
    spatz_mem_resp_t e;
    bit stalled = 1'b0;
    always @(negedge clk) begin
        if (rst_i) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 64'(mem_rsp_valid_o), 64'h1);
                chk("stall_hold", 64'(mem_rsp_o), 64'(held));
            end
            stalled = 1'b0;
            if (mem_rsp_valid_o) begin
                got = mem_rsp_o;
                if (!mem_rsp_ready_i) begin
                    stalled = 1'b1;
                    held = got;
                end else begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp: got %h want none", got);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp", 64'(got), 64'(e));
                    end
                    last_rsp = got;
                    rsp_cnt++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    bit done = 1'b0;
    int a0;
    int r0;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(mem_req_ready_o), 64'h0);
        chk("reset_valid", 64'(mem_rsp_valid_o), 64'h0);
        chk("reset_rsp", 64'(mem_rsp_o), 64'h0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(mem_req_ready_o), 64'h1);
        @(posedge clk); #1;

        mem_rsp_ready_i = 1'b1;
        for (int w = 0; w < 32; w++)
            send(mkreq(6'($urandom), BASE + 32'(4 * w), 1'b1, 4'hF, $urandom, 1'b0));
        wait_idle();

        send(mkreq(6'h00, BASE + 32'd8, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0));
        send(mkreq(6'h05, BASE + 32'd8, 1'b0, 4'h0, 32'h0, 1'b0));
        @(negedge clk);
        chk("load_latency", 64'(mem_rsp_valid_o), 64'h1);
        wait_idle();
        chk("full_store", 64'(last_rsp), 64'(mk(5'h05, 32'hDEAD_BEEF, 1'b0)));

        send(mkreq(6'h00, BASE + 32'd8, 1'b1, 4'b0011, 32'h1234_5678, 1'b0));
        send(mkreq(6'h07, BASE + 32'd8, 1'b0, 4'h0, 32'h0, 1'b0));
        wait_idle();
        chk("partial_store", 64'(last_rsp.rdata), 64'hDEAD_5678);

        send(mkreq(6'h21, BASE + 32'(NW * 4), 1'b0, 4'h0, 32'h0, 1'b0));
        wait_idle();
        chk("oor_err", 64'(last_rsp), 64'(mk(5'h01, 32'h0, 1'b1)));
        send(mkreq(6'h21, BASE + 32'(NW * 4), 1'b0, 4'h0, 32'h0, 1'b1));
        wait_idle();
        chk("oor_spec", 64'(last_rsp), 64'(mk(5'h01, 32'h0, 1'b0)));
        send(mkreq(6'h02, BASE + 32'(NW * 4), 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0));
        send(mkreq(6'h03, BASE - 32'd4, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1));
        send(mkreq(6'h04, BASE, 1'b0, 4'h0, 32'h0, 1'b0));
        wait_idle();

        mem_rsp_ready_i = 1'b0;
        a0 = acc_cnt;
        r0 = rsp_cnt;
        fork
            for (int i = 0; i < 8; i++)
                send(mkreq(6'(i), BASE + 32'(4 * i), 1'b0, 4'h0, 32'h0, 1'b0));
            begin
                repeat (12) @(posedge clk);
                @(negedge clk);
                chk("credit_accepts", 64'(acc_cnt - a0), 64'd4);
                chk("credit_ready", 64'(mem_req_ready_o), 64'h0);
                @(posedge clk); #1;
                mem_rsp_ready_i = 1'b1;
            end
        join
        wait_idle();
        chk("burst_count", 64'(rsp_cnt - r0), 64'd8);

        mem_rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++)
            send(mkreq(6'(i + 10), BASE + 32'(4 * i), 1'b0, 4'h0, 32'h0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_valid", 64'(mem_rsp_valid_o), 64'h0);
        chk("midrst_ready", 64'(mem_req_ready_o), 64'h0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("postrst_valid", 64'(mem_rsp_valid_o), 64'h0);
        chk("postrst_ready", 64'(mem_req_ready_o), 64'h1);
        @(posedge clk); #1;
        mem_rsp_ready_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(mkreq(6'h09, BASE + 32'd8, 1'b0, 4'h0, 32'h0, 1'b0));
        wait_idle();
        chk("sram_kept", 64'(last_rsp.rdata), 64'hDEAD_5678);

        mem_rsp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++)
            send(mkreq(6'(i + 20), BASE + 32'(4 * (40 + i)), 1'b1, 4'hF, $urandom, 1'b0));
        @(negedge clk);
`ifdef SPATZ_MEM_RSP_STORE_ACK_EN
        chk("ack_credit_ready", 64'(mem_req_ready_o), 64'h0);
`else
        chk("store_no_credit", 64'(mem_req_ready_o), 64'h1);
`endif
        @(posedge clk); #1;
        wait_idle();

        fork
            while (!done) begin
                mem_rsp_ready_i = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            begin
                for (int n = 0; n < 400; n++) begin
                    spatz_mem_req_t r;
                    int sel;
                    r = spatz_mem_req_t'({$urandom, $urandom, $urandom});
                    sel = $urandom_range(0, 9);
                    if (sel < 8)
                        r.addr = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
                    else if (sel == 8)
                        r.addr = BASE + 32'(NW * 4) + 32'($urandom_range(0, 255));
                    else
                        r.addr = BASE - 32'd1 - 32'($urandom_range(0, 15));
                    send(r);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
        join
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spatz_mem_responder.md
Name: spatz_mem_responder

Overview:
- Responder end of the Spatz VLSU memory port.
- Accepts spatz_mem_req_t requests on a valid/ready handshake and services them from an internal word-addressed SRAM.
- Returns spatz_mem_resp_t responses in order through a credit-protected response FIFO.
- Used as the TCDM-side model and adapter behind the VLSU for cluster-level simulation and small on-chip scratchpads.

Parameters:
- NumWords, 1024, SRAM depth in ELEN-bit words.
- BaseAddr, 32'h0000_0000, byte address of word 0; must be ELENB-aligned.
- RspFifoDepth, 4, response FIFO entries (>=2, power of two).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mem_req_i  in  $bits(spatz_mem_req_t)  request: id, addr, mode, size, we, strb, wdata, last, spec
- mem_req_valid_i  in  1  request valid
- mem_req_ready_o  out  1  request accepted when valid&&ready
- mem_rsp_o  out  $bits(spatz_mem_resp_t)  response: id, rdata, err
- mem_rsp_valid_o  out  1  response valid
- mem_rsp_ready_i  in  1  response consumed when valid&&ready

Behaviour:
- Widths: ELEN and ELENB come from spatz_pkg. Request id is $clog2(NRVREG)+1 bits; response id is req.id[$clog2(NRVREG)-1:0], i.e. the MSB is dropped.
- Address decode: word index = (addr - BaseAddr) >> $clog2(ELENB). Low offset bits are ignored. In range iff BaseAddr <= addr < BaseAddr + NumWords*ELENB.
- mode and size are ignored. Loads always return the full word. last is ignored.
- Load (we=0), accepted cycle T:
  - SRAM read in T.
  - Response {id, rdata, err} written into the FIFO at the T+1 edge.
  - mem_rsp_valid_o high from T+1 if the FIFO was empty, so minimum latency is 1 cycle.
- Store (we=1), accepted cycle T:
  - Bytes with strb[b]=1 are written at the T edge; other bytes are unchanged.
  - No response is produced.
  - A load to the same word accepted at T+1 returns the new data.
- Out-of-range load:
  - spec=0: rdata=0, err=1.
  - spec=1: rdata=0, err=0 (speculative fault suppressed).
- Out-of-range store: dropped, no SRAM write, no response.
- Credit rule: mem_req_ready_o = !rst_i && (fifo_count + inflight_loads < RspFifoDepth).
  - inflight_loads is 0 or 1: the load accepted in the previous cycle but not yet written into the FIFO.
  - Stores bypass the credit check only when ready is already high. Ready is never asserted combinationally from req.we.
- FIFO:
  - In-order, one push per cycle and one pop per cycle.
  - Simultaneous push and pop while full is legal, because credits guarantee no overflow.
  - Pop and push on the same cycle with count=1 keeps valid high.
  - Response outputs hold stable while valid && !ready.
- Responses are never reordered, duplicated, or dropped once the request is accepted.
- Reset, including when asserted mid-operation:
  - FIFO flushed; inflight cleared.
  - mem_rsp_valid_o=0, mem_rsp_o=0, mem_req_ready_o=0 while rst_i=1.
  - SRAM contents are not reset.
  - mem_req_ready_o rises the cycle after rst_i deasserts.
- Assertions:
  - FIFO never overflows.
  - mem_req_i stable while valid && !ready.

Optional Feature:
- Macro: SPATZ_MEM_RSP_STORE_ACK_EN.
- Defined:
  - Every accepted store also produces a response: id=req.id truncated, rdata=0, err=1 only for an out-of-range store with spec=0.
  - Stores consume a credit exactly like loads, so ready uses the same count+inflight check for both.
- Undefined: stores are silent, as described in Behaviour.

Test Plan:
- Store addr=BaseAddr+8, wdata=32'hDEAD_BEEF, strb=4'hF, then load addr+8 with id=6'h05 -> one response: id=5'h05, rdata=32'hDEAD_BEEF, err=0, valid 1 cycle after load accept.
- Partial store strb=4'b0011, wdata=32'h1234_5678 over 32'hDEAD_BEEF -> subsequent load returns 32'hDEAD_5678.
- Load id=6'h21 at addr=BaseAddr+NumWords*4 with spec=0 -> id=5'h01, rdata=0, err=1; same access with spec=1 -> err=0, and no store side effect.
- Hold mem_rsp_ready_i=0 and issue back-to-back loads ids 0..7:
  - ready drops after 4 accepts (RspFifoDepth=4);
  - release ready -> responses arrive with ids 0..7 in order, none lost, outputs stable while stalled.
- Assert rst_i for 1 cycle with 3 responses queued -> valid=0 the next cycle, no stale responses afterwards, earlier stored data still readable.
- With SPATZ_MEM_RSP_STORE_ACK_EN defined, 4 stores with rsp_ready=0 -> ready drops after 4; each store returns an ack with rdata=0, err=0.
